// File: rtl/data_mem_if.sv
// Data-memory port bundle between the CPU datapath (master) and the memory responder (slave).
interface data_mem_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 mem_ren;
  logic                 mem_wen;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_dout;
  logic [31:0]          mem_din;
  logic                 mem_stall;
  logic                 mem_ack;
  logic                 mem_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, mem_ack, mem_err, err_cnt
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, mem_ack, mem_err, err_cnt
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM served with a fixed wait-state count,
// rejecting misaligned, out-of-range and simultaneous read/write accesses.
//
// state | meaning
// IDLE  | no access in flight; a request is latched at the end of the cycle
// WAIT  | access in flight; cnt==0 marks the ack cycle
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  data_mem_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  wr_q;
  logic                  bad_q;

  logic [31:0] ram [2**ADDR_WIDTH];

  logic                  req;
  logic                  bad_now;
  logic [ADDR_WIDTH-1:0] idx_now;
  logic                  enter_ack;
  logic                  ack_now;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_bad;
  logic                  rd_op;

  assign req     = bus.mem_ren | bus.mem_wen;
  assign bad_now = (bus.mem_addr[1:0] != 2'b00) | (|bus.mem_addr[31:ADDR_WIDTH+2])
                 | (bus.mem_ren & bus.mem_wen);
  assign idx_now = bus.mem_addr[ADDR_WIDTH+1:2];

  // With LATENCY=1 the ack cycle is entered straight from IDLE, so the
  // read path must use the live request rather than the latched one.
  assign enter_ack = ((state == IDLE) && req && (LAT_M1 == 4'd0))
                   || ((state == WAIT) && (cnt == 4'd1));
  assign ack_now   = (state == WAIT) && (cnt == 4'd0);
  assign rd_idx    = (state == IDLE) ? idx_now : idx_q;
  assign rd_bad    = (state == IDLE) ? bad_now : bad_q;
  assign rd_op     = (state == IDLE) ? bus.mem_ren : ~wr_q;

  assign bus.mem_stall = ((state == IDLE) && req) || ((state == WAIT) && (cnt != 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      bad_q       <= 1'b0;
      bus.mem_din <= '0;
      bus.mem_ack <= 1'b0;
      bus.mem_err <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.mem_ack <= enter_ack;
      bus.mem_err <= enter_ack & rd_bad;
      if (enter_ack) begin
        if (rd_bad)
          bus.mem_din <= '0;
        else if (rd_op)
          bus.mem_din <= ram[rd_idx];
      end
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= idx_now;
            wdata_q <= bus.mem_dout;
            wr_q    <= bus.mem_wen;
            bad_q   <= bad_now;
            cnt     <= LAT_M1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (bad_q && (bus.err_cnt != '1))
              bus.err_cnt <= bus.err_cnt + ERR_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ack_now && wr_q && !bad_q)
      ram[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 responder for the main sequence, LATENCY=1 responder
// for back-to-back traffic; inputs change and outputs are sampled around negedge.
module tb_data_mem_responder;
  logic clk;
  logic rst_n;
  logic sel;
  logic r, w;
  logic [31:0] a, d;
  int tests_run;
  int tests_failed;

  data_mem_if #(.ERR_CNT_W(8)) bus1 ();
  data_mem_if #(.ERR_CNT_W(8)) bus2 ();

  assign bus1.mem_ren  = ~sel & r;
  assign bus1.mem_wen  = ~sel & w;
  assign bus1.mem_addr = sel ? 32'h0 : a;
  assign bus1.mem_dout = sel ? 32'h0 : d;
  assign bus2.mem_ren  = sel & r;
  assign bus2.mem_wen  = sel & w;
  assign bus2.mem_addr = sel ? a : 32'h0;
  assign bus2.mem_dout = sel ? d : 32'h0;

  logic [31:0] o_din;
  logic        o_stall, o_ack, o_err;
  logic [7:0]  o_cnt;
  assign o_din   = sel ? bus2.mem_din   : bus1.mem_din;
  assign o_stall = sel ? bus2.mem_stall : bus1.mem_stall;
  assign o_ack   = sel ? bus2.mem_ack   : bus1.mem_ack;
  assign o_err   = sel ? bus2.mem_err   : bus1.mem_err;
  assign o_cnt   = sel ? bus2.err_cnt   : bus1.err_cnt;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .ERR_CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in an IDLE cycle; returns after the ack,
  // just after the negedge of the following IDLE cycle with the request dropped.
  task automatic access(input logic r_i, input logic w_i, input logic [31:0] a_i,
                        input logic [31:0] d_i, input logic exp_err, input logic chk_din,
                        input logic [31:0] exp_din, input int lat, input string tag);
    r = r_i; w = w_i; a = a_i; d = d_i;
    for (int k = 0; k < lat; k++) begin
      #1;
      check({tag, "_stall"}, 32'(o_stall), 32'd1);
      check({tag, "_noack"}, 32'(o_ack), 32'd0);
      @(negedge clk);
    end
    #1;
    check({tag, "_ack"}, 32'(o_ack), 32'd1);
    check({tag, "_ackstall"}, 32'(o_stall), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    if (chk_din) check({tag, "_din"}, o_din, exp_din);
    @(negedge clk);
    r = 1'b0; w = 1'b0;
    #1;
    check({tag, "_ackpulse"}, 32'(o_ack), 32'd0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    sel = 1'b0; r = 1'b0; w = 1'b0; a = '0; d = '0;
    rst_n = 1'b0;
    #12;
    check("rst_din", o_din, 32'd0);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_errcnt", 32'(o_cnt), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Tests 1/2: write then read back, din held through a later write
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2, "t1_wr");
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2, "t2_rd");
    access(1'b0, 1'b1, 32'h44, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF, 2, "t2_hold");
    check("t2_hold_after", o_din, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 2, "pre_wr0");

    // Test 3: misaligned read
    access(1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1, 32'h0, 2, "t3_mis");
    check("t3_errcnt", 32'(o_cnt), 32'd1);
    // Test 3b: out-of-range write would alias to word 0 if accepted
    access(1'b0, 1'b1, 32'h1000, 32'h55555555, 1'b1, 1'b0, 32'h0, 2, "t3b_oor");
    check("t3b_errcnt", 32'(o_cnt), 32'd2);
    // Test 4: simultaneous read and write
    access(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 2, "t4_both");
    check("t4_errcnt", 32'(o_cnt), 32'd3);
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, 2, "t4_rd0");

    // Test 4b: held misaligned request restarts every 3 cycles
    r = 1'b1; a = 32'h3;
    repeat (251 * 3) @(negedge clk);
    r = 1'b0;
    #1 check("t4b_errcnt_254", 32'(o_cnt), 32'hFE);
    @(negedge clk);
    r = 1'b1;
    repeat (49 * 3) @(negedge clk);
    r = 1'b0;
    #1 check("t4b_errcnt_sat", 32'(o_cnt), 32'hFF);
    @(negedge clk);

    // Test 5: reset in the WAIT cycle discards the write
    access(1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0, 1'b0, 32'h0, 2, "t5_wr");
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h12345678, 2, "t5_rd");
    w = 1'b1; a = 32'h8; d = 32'h87654321;
    #1 check("t5_stall", 32'(o_stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    w = 1'b0;
    #1;
    check("t5_rst_din", o_din, 32'd0);
    check("t5_rst_ack", 32'(o_ack), 32'd0);
    check("t5_rst_err", 32'(o_err), 32'd0);
    check("t5_rst_errcnt", 32'(o_cnt), 32'd0);
    check("t5_rst_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    #1 check("t5_rst_noack", 32'(o_ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h12345678, 2, "t5_rd_after");

    // Test 6: LATENCY=1 responder, back-to-back traffic
    sel = 1'b1;
    access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1, "t6_wr0");
    access(1'b0, 1'b1, 32'h14, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0, 1, "t6_wr1");
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1, "t6_rd0");
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0BADC0DE, 1, "t6_rd1");
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1, "t6_rd2");
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0BADC0DE, 1, "t6_rd3");
    check("t6_errcnt", 32'(o_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
